seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexing scan controller that shares one BCD-to-7-segment decoder among `DIGITS` common-anode digits. It holds a double-buffered frame of BCD nibbles, steps through the digits at a programmable refresh rate, and drives the shared decoder input and the active-low digit enables. New frames are accepted through a valid/ready handshake and swapped in only at frame boundaries, so a display never shows a torn value.

## Interface
- `DIGITS`, default 4, is the number of multiplexed digits (2..8).
- `DIV`, default 50000, is the number of clock cycles per digit slot (≥ 2).
- `GUARD`, default 2, is the number of anti-ghosting cycles at the start of each slot during which all anodes are off (0 ≤ GUARD < DIV).

Ports:
- `clk` input, 1 bit: the single clock; all state is updated on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `ld_valid` input, 1 bit: a new frame is present on `ld_data`.
- `ld_data` input, 4*DIGITS bits: the frame; digit i is `ld_data[4i+3:4i]`, and digit 0 is the rightmost (least significant) digit.
- `ld_ready` output, 1 bit: the block can accept a frame.
- `bcd` output, 4 bits: the code for the shared decoder. Bit 0 goes to decoder input `w` (LSB) and bit 3 to `z`. The value 4'hF blanks the digit, because the decoder's default case turns all segments off.
- `an_n` output, DIGITS bits: active-low one-hot digit enables.
- `frame_done` output, 1 bit: a one-cycle pulse at the end of each full scan.

## Operation
- **State:**
  - `tick` counts 0..DIV-1.
  - `idx` is the digit index, 0..DIGITS-1.
  - `shadow` is the frame currently displayed.
  - `pend` and `pend_v` form the one-deep pending buffer and its flag.
- **Scan:**
  - `tick` increments every cycle. At DIV-1 it wraps to 0 and `idx` advances.
  - `idx` wraps from DIGITS-1 to 0.
- **Frame boundary:** the cycle with `tick==DIV-1` and `idx==DIGITS-1`.
  - `frame_done` asserts on the following cycle.
  - If `pend_v` is set at the boundary, then `shadow<=pend` and `pend_v<=0`.
- **Handshake:**
  - `ld_ready = ~pend_v`.
  - A transfer happens when `ld_valid & ld_ready` at a rising edge: `pend<=ld_data` and `pend_v<=1`.
  - A transfer on the boundary cycle itself lands in `pend` and is swapped at the next boundary. It is never written directly into `shadow`.
  - `ld_data` is sampled only on the transfer edge.
- **Outputs:** both are registered.
  - `bcd <= shadow[4*idx+3:4*idx]`, subject to blanking (see Configuration).
  - `an_n <= (tick < GUARD) ? all-ones : ~(1<<idx)`.
- **Reset:** while `rst_n` is low, state is cleared immediately, including mid-scan or mid-handshake. A pending frame is discarded.
  - `tick=0`, `idx=0`, `shadow` = all 4'hF, `pend_v=0`.
  - Outputs: `bcd=4'hF`, `an_n` all ones, `ld_ready=1`, `frame_done=0`.

## Timing
- `bcd` and `an_n` lag `tick`/`idx` by one cycle.
- An enabled digit is lit for DIV-GUARD cycles per slot.
- A full frame takes DIGITS*DIV cycles.
- Load-to-display latency:
  - Minimum: 2 cycles, when the transfer occurs the cycle before a boundary.
  - Maximum: DIGITS*DIV+1 cycles.
- `ld_ready` falls the cycle after a transfer. It rises the cycle after the boundary that consumes `pend`.
- Once `rst_n` is released, the first slot shows digit 0 with `tick` counting from 0.
- `frame_done` first fires DIGITS*DIV cycles after release.

## Configuration
- `SEG_SCAN_LZB_EN` enables leading-zero blanking.
  - **Defined:** a digit whose value is 0 is output as 4'hF if every more-significant digit in `shadow` is also 0 or 4'hF. Digit 0 is never blanked, so 0000 displays as a single "0".
  - **Undefined:** `bcd` passes `shadow` nibbles unchanged.

## Test plan
Use DIGITS=4, DIV=4, GUARD=1 for all scenarios.
1. **Reset and first frame.**
   - Release reset with no load.
   - Required: `bcd` is 4'hF throughout.
   - Required: `an_n` cycles 1111,1110,1110,1110 then 1111,1101,… .
   - Required: `frame_done` pulses every 16 cycles.
2. **Load and swap.**
   - Stimulus: transfer 16'h4321 at cycle 3.
   - Required: `ld_ready` goes low.
   - Required: after the next boundary, `bcd` reads 1,2,3,4 during the enabled windows of digits 0..3, and `ld_ready` returns high.
3. **Backpressure.**
   - Stimulus: hold `ld_valid` with 16'h9999 while `pend_v` is set.
   - Required: no transfer until `ld_ready` rises; the frame then appears one boundary later.
4. **Boundary-coincident load.**
   - Stimulus: a transfer on the boundary cycle.
   - Required: the old frame is displayed for one more full frame before the swap.
5. **Reset mid-operation.**
   - Stimulus: assert `rst_n` low while `pend_v=1`, mid-slot.
   - Required: outputs return to their reset values asynchronously, and the pending frame never appears.
6. **Leading-zero blanking.** Load 16'h0050.
   - With `SEG_SCAN_LZB_EN`: digits 3..0 show F,F,5,0.
   - Without it: digits 3..0 show 0,0,5,0.
   - Loading 16'h0000 with the macro defined: F,F,F,0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for DIGITS common-anode 7-segment digits
// that share one BCD-to-7-segment decoder. A double-buffered frame of BCD
// nibbles is scanned one digit slot at a time. A newly loaded frame waits in a
// one-deep pending buffer and replaces the displayed frame only at a frame
// boundary, so a scan never mixes digits from two frames.
//
// Parameters:
//   DIGITS  number of multiplexed digits (2..8)
//   DIV     clock cycles per digit slot (>= 2)
//   GUARD   anti-ghosting cycles at the start of each slot with all anodes
//           off (0 <= GUARD < DIV)
//
// Ports:
//   clk         clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   ld_valid    a new frame is offered on ld_data
//   ld_data     frame, digit i = ld_data[4i+3:4i], digit 0 is rightmost
//   ld_ready    a frame can be accepted (pending buffer empty)
//   bcd         registered code for the shared decoder (4'hF = blank)
//   an_n        registered active-low one-hot digit enables
//   frame_done  one-cycle pulse the cycle after each frame boundary
//
// Build option:
//   SEG_SCAN_LZB_EN  when defined, leading zeros are blanked (digit 0 is
//                    never blanked). When undefined, nibbles pass unchanged.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  input  logic [4*DIGITS-1:0]   ld_data,
  output logic                  ld_ready,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [TICK_W-1:0] GUARD_T   = TICK_W'(GUARD);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  // Scan position
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Frame buffers
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_v_q, pend_v_d;

  // Registered outputs
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic                frame_done_q, frame_done_d;

  logic                boundary;
  logic                xfer;
  logic [3:0]          nib [DIGITS];

  // Load handshake: a frame transfers on a rising edge where ld_valid and
  // ld_ready are both high; ld_data is sampled only on that edge. ld_ready is
  // high exactly while the pending buffer is empty, and it does not depend on
  // ld_valid. Once a frame is pending, further offers are held off until the
  // next frame boundary moves it into the displayed frame.
  assign ld_ready = ~pend_v_q;
  assign xfer     = ld_valid & ~pend_v_q;

  // Last cycle of the last digit slot of a scan.
  assign boundary = (tick_q == TICK_LAST) && (idx_q == IDX_LAST);

  // Scan counters and frame buffers
  always_comb begin
    tick_d   = tick_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
    end

    if (boundary && pend_v_q) begin
      shadow_d = pend_q;
      pend_v_d = 1'b0;
    end

    // A transfer needs an empty pending buffer, so it can never coincide with
    // the swap above; a transfer on the boundary edge waits a full frame.
    if (xfer) begin
      pend_d   = ld_data;
      pend_v_d = 1'b1;
    end
  end

  // Displayed nibbles, with optional leading-zero blanking
  always_comb begin
`ifdef SEG_SCAN_LZB_EN
    logic lead_zero;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      nib[i] = shadow_q[4*i +: 4];
    end
`ifdef SEG_SCAN_LZB_EN
    // Walk from the most significant digit down; lead_zero stays set while
    // every digit seen so far is 0 or already blank. Digit 0 is excluded.
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead_zero && (shadow_q[4*i +: 4] == 4'h0)) begin
        nib[i] = 4'hF;
      end
      lead_zero = lead_zero &&
                  ((shadow_q[4*i +: 4] == 4'h0) || (shadow_q[4*i +: 4] == 4'hF));
    end
`endif
  end

  // Output next-state
  always_comb begin
    bcd_d = 4'hF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        bcd_d = nib[i];
      end
    end
    an_n_d       = (tick_q < GUARD_T) ? {DIGITS{1'b1}} : ~(DIGITS'(1) << idx_q);
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q       <= '0;
      idx_q        <= '0;
      shadow_q     <= {DIGITS{4'hF}};
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      bcd_q        <= 4'hF;
      an_n_q       <= {DIGITS{1'b1}};
      frame_done_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      bcd_q        <= bcd_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd        = bcd_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
